gpc_4t_ifetch: RTL and testbench

//  Instruction-fetch front end for the 4-thread GPC core. Sits directly upstream of the core port (port a) of the instruction memory.

---
 rtl/gpc_4t_ifetch_pkg.sv | 23 ++
 rtl/gpc_4t_ifetch_if.sv | 31 +++
 rtl/gpc_4t_ifetch_rr_arb.sv | 27 ++
 rtl/gpc_4t_ifetch.sv | 110 +++++++++++
 tb/tb_gpc_4t_ifetch.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/gpc_4t_ifetch_pkg.sv
// Shared types and sizes for the 4-thread GPC instruction-fetch front end.
package gpc_4t_ifetch_pkg;

  localparam int NUM_THREADS = 4;
  localparam int TID_W       = $clog2(NUM_THREADS);
  localparam int MSB_I_MEM   = 11;
  localparam int ADDR_W      = MSB_I_MEM - 1;

  typedef logic [TID_W-1:0] t_tid;

  typedef struct packed {
    logic        vld;
    t_tid        tid;
    logic [31:0] pc;
    logic [31:0] inst;
  } t_fetch_pkt;

  // Word address seen by the i-mem port; PC bits above MSB_I_MEM simply wrap.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [31:0] pc);
    return ADDR_W'(pc >> 2);
  endfunction

endpackage

// File: rtl/gpc_4t_ifetch_if.sv
// Bundle of fetch-unit control, i-mem port a and decode-side signals.
interface gpc_4t_ifetch_if;
  import gpc_4t_ifetch_pkg::*;

  logic [NUM_THREADS-1:0]    thread_en;
  logic [32*NUM_THREADS-1:0] thread_rst_pc;
  logic                      redirect_valid;
  t_tid                      redirect_tid;
  logic [31:0]               redirect_pc;
  logic                      stall;
  logic [ADDR_W-1:0]         imem_address;
  logic                      imem_rden;
  logic [31:0]               imem_q;
  logic                      inst_valid;
  t_tid                      inst_tid;
  logic [31:0]               inst_pc;
  logic [31:0]               instruction;

  modport master (
    input  thread_en, thread_rst_pc, redirect_valid, redirect_tid, redirect_pc,
    input  stall, imem_q,
    output imem_address, imem_rden, inst_valid, inst_tid, inst_pc, instruction
  );

  modport slave (
    output thread_en, thread_rst_pc, redirect_valid, redirect_tid, redirect_pc,
    output stall, imem_q,
    input  imem_address, imem_rden, inst_valid, inst_tid, inst_pc, instruction
  );

endinterface

// File: rtl/gpc_4t_ifetch_rr_arb.sv
// Round-robin thread picker: grants the first requester after 'last', wrapping.
module gpc_4t_rr_arb
  import gpc_4t_ifetch_pkg::*;
(
  input  logic [NUM_THREADS-1:0] req,
  input  t_tid                   last,
  output t_tid                   gnt_tid,
  output logic                   gnt_vld
);

  t_tid idx;

  // Scan from last+1 around to last itself; the first requester found wins.
  always_comb begin
    gnt_tid = '0;
    gnt_vld = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      idx = last + t_tid'(i);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_tid = idx;
      end
    end
  end

endmodule

// File: rtl/gpc_4t_ifetch.sv
// Instruction-fetch front end: per-thread PCs, round-robin issue to a
// registered-output i-mem, one-cycle delivery with a stall hold buffer.
module gpc_4t_ifetch
  import gpc_4t_ifetch_pkg::*;
(
  input logic             clock,
  input logic             rst,
  gpc_4t_ifetch_if.master bus
);

  logic [31:0]            pc [NUM_THREADS];
  t_tid                   rr_last;
  logic                   f2_vld;
  t_tid                   f2_tid;
  logic [31:0]            f2_pc;
  logic                   hold_vld;
  logic [31:0]            hold_q;

  logic [NUM_THREADS-1:0] cand;
  t_tid                   sel;
  logic                   sel_vld;
  logic                   kill;
  logic                   inst_valid_int;
  logic                   stall_eff;
  logic                   issue;
  t_fetch_pkt             out_pkt;

  // A thread being redirected this cycle is not a fetch candidate.
  always_comb begin
    cand = '0;
    for (int t = 0; t < NUM_THREADS; t++) begin
      cand[t] = bus.thread_en[t] &
                ~(bus.redirect_valid && (bus.redirect_tid == t_tid'(t)));
    end
  end

  gpc_4t_rr_arb u_arb (
    .req     (cand),
    .last    (rr_last),
    .gnt_tid (sel),
    .gnt_vld (sel_vld)
  );

  // Issue/deliver decisions; a stall only bites when something is on offer.
  always_comb begin
    kill           = bus.redirect_valid && (bus.redirect_tid == f2_tid);
    inst_valid_int = f2_vld & ~kill & ~rst;
    stall_eff      = bus.stall & inst_valid_int;
    issue          = sel_vld & ~stall_eff & ~rst;
    out_pkt        = '0;
    if (!rst) begin
      out_pkt.vld  = inst_valid_int;
      out_pkt.tid  = f2_tid;
      out_pkt.pc   = f2_pc;
      out_pkt.inst = hold_vld ? hold_q : bus.imem_q;
    end
  end

  assign bus.imem_rden    = issue;
  assign bus.imem_address = word_addr(pc[sel]);
  assign bus.inst_valid   = out_pkt.vld;
  assign bus.inst_tid     = out_pkt.tid;
  assign bus.inst_pc      = out_pkt.pc;
  assign bus.instruction  = out_pkt.inst;

  // Per-thread PCs: a redirect wins over the post-issue increment.
  always_ff @(posedge clock) begin
    if (rst) begin
      for (int t = 0; t < NUM_THREADS; t++)
        pc[t] <= bus.thread_rst_pc[32*t +: 32] & 32'hFFFF_FFFC;
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (bus.redirect_valid && (bus.redirect_tid == t_tid'(t)))
          pc[t] <= bus.redirect_pc & 32'hFFFF_FFFC;
        else if (issue && (sel == t_tid'(t)))
          pc[t] <= pc[t] + 32'd4;
      end
    end
  end

  // Round-robin pointer and the F2 slot; F2 freezes while decode stalls.
  always_ff @(posedge clock) begin
    if (rst) begin
      rr_last <= t_tid'(NUM_THREADS - 1);
      f2_vld  <= 1'b0;
      f2_tid  <= '0;
      f2_pc   <= '0;
    end else if (issue) begin
      rr_last <= sel;
      f2_vld  <= 1'b1;
      f2_tid  <= sel;
      f2_pc   <= pc[sel];
    end else if (!stall_eff) begin
      f2_vld  <= 1'b0;
    end
  end

  // Capture the memory word on the first stall cycle since its output drops with rden.
  always_ff @(posedge clock) begin
    if (rst) begin
      hold_vld <= 1'b0;
      hold_q   <= '0;
    end else begin
      hold_vld <= stall_eff;
      if (stall_eff && !hold_vld)
        hold_q <= bus.imem_q;
    end
  end

endmodule

// File: tb/tb_gpc_4t_ifetch.sv
// Directed-vector bench for gpc_4t_ifetch with a registered-output i-mem model.
module tb_gpc_4t_ifetch;
  import gpc_4t_ifetch_pkg::*;

  logic clock = 1'b0;
  logic rst   = 1'b1;
  logic [31:0] imem_q_r = 32'h0;

  always #5 clock = ~clock;

  gpc_4t_ifetch_if bus ();

  gpc_4t_ifetch dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    if (a == 10'h2B0) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // I-mem port a: registered output that reads 0 when not enabled.
  always @(posedge clock)
    imem_q_r <= bus.imem_rden ? mem_word(bus.imem_address) : 32'h0;

  assign bus.imem_q = imem_q_r;

  typedef struct {
    string       name;
    logic        rst;
    logic [3:0]  en;
    logic        rv;
    t_tid        rtid;
    logic [31:0] rpc;
    logic        stall;
    logic        rden;
    logic [9:0]  addr;
    logic        valid;
    t_tid        tid;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs[$];
  int   applied     = 0;
  int   miscompares = 0;

  function automatic void add(input string name, input logic r, input logic [3:0] en,
                              input logic rv, input t_tid rtid, input logic [31:0] rpc,
                              input logic st, input logic rden, input logic [9:0] addr,
                              input logic valid, input t_tid tid, input logic [31:0] pc,
                              input logic [31:0] inst);
    vec_t v;
    v.name = name;  v.rst = r;       v.en = en;     v.rv = rv;
    v.rtid = rtid;  v.rpc = rpc;     v.stall = st;  v.rden = rden;
    v.addr = addr;  v.valid = valid; v.tid = tid;   v.pc = pc;
    v.inst = inst;
    vecs.push_back(v);
  endfunction

  task automatic apply_stimulus(input vec_t v);
    rst                = v.rst;
    bus.thread_en      = v.en;
    bus.redirect_valid = v.rv;
    bus.redirect_tid   = v.rtid;
    bus.redirect_pc    = v.rpc;
    bus.stall          = v.stall;
  endtask

  task automatic cmp(input string name, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s %s: got %0h want %0h", name, field, got, want);
    end
  endtask

  task automatic check_output(input vec_t v);
    cmp(v.name, "imem_rden", 32'(bus.imem_rden), 32'(v.rden));
    if (v.rden)
      cmp(v.name, "imem_address", 32'(bus.imem_address), 32'(v.addr));
    cmp(v.name, "inst_valid", 32'(bus.inst_valid), 32'(v.valid));
    if (v.valid || v.rst) begin
      cmp(v.name, "inst_tid", 32'(bus.inst_tid), 32'(v.tid));
      cmp(v.name, "inst_pc", bus.inst_pc, v.pc);
      cmp(v.name, "instruction", bus.instruction, v.inst);
    end
  endtask

  task automatic run_vec(input vec_t v);
    apply_stimulus(v);
    @(negedge clock);
    check_output(v);
    applied++;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vec_t h;
    bus.thread_rst_pc  = {32'h300, 32'h200, 32'h100, 32'h000};
    bus.thread_en      = 4'hF;
    bus.redirect_valid = 1'b0;
    bus.redirect_tid   = '0;
    bus.redirect_pc    = '0;
    bus.stall          = 1'b0;
    @(posedge clock);
    #1;

    // name  rst en  rv tid rpc  stall rden addr  valid tid pc  inst
    add("rst0",  1, 4'hF, 0, 0, 0, 0, 0, 10'h000, 0, 0, 32'h0,   32'h0);
    add("rr1",   0, 4'hF, 0, 0, 0, 0, 1, 10'h000, 0, 0, 32'h0,   32'h0);
    add("rr2",   0, 4'hF, 0, 0, 0, 0, 1, 10'h040, 1, 0, 32'h000, 32'hC0DE0000);
    add("rr3",   0, 4'hF, 0, 0, 0, 0, 1, 10'h080, 1, 1, 32'h100, 32'hC0DE0040);
    add("rr4",   0, 4'hF, 0, 0, 0, 0, 1, 10'h0C0, 1, 2, 32'h200, 32'hC0DE0080);
    add("rr5",   0, 4'hF, 0, 0, 0, 0, 1, 10'h001, 1, 3, 32'h300, 32'hC0DE00C0);
    add("rr6",   0, 4'hF, 0, 0, 0, 0, 1, 10'h041, 1, 0, 32'h004, 32'hC0DE0001);
    add("en5a",  0, 4'h5, 0, 0, 0, 0, 1, 10'h081, 1, 1, 32'h104, 32'hC0DE0041);
    add("en5b",  0, 4'h5, 0, 0, 0, 0, 1, 10'h002, 1, 2, 32'h204, 32'hC0DE0081);
    add("en5c",  0, 4'h5, 0, 0, 0, 0, 1, 10'h082, 1, 0, 32'h008, 32'hC0DE0002);
    add("en5d",  0, 4'h5, 0, 0, 0, 0, 1, 10'h003, 1, 2, 32'h208, 32'hC0DE0082);
    add("t0a",   0, 4'h1, 0, 0, 0, 0, 1, 10'h004, 1, 0, 32'h00C, 32'hC0DE0003);
    add("rdk",   0, 4'h1, 1, 0, 32'h83, 0, 0, 10'h000, 0, 0, 32'h0, 32'h0);
    add("rdk1",  0, 4'h1, 0, 0, 0, 0, 1, 10'h020, 0, 0, 32'h0,   32'h0);
    add("rdk2",  0, 4'h1, 0, 0, 0, 0, 1, 10'h021, 1, 0, 32'h080, 32'hC0DE0020);
    add("rd2",   0, 4'h5, 1, 2, 32'hAC0, 0, 1, 10'h022, 1, 0, 32'h084, 32'hC0DE0021);
    add("rd2b",  0, 4'h5, 0, 0, 0, 0, 1, 10'h2B0, 1, 0, 32'h088, 32'hC0DE0022);
    add("stl1",  0, 4'h5, 0, 0, 0, 1, 0, 10'h000, 1, 2, 32'hAC0, 32'hDEADBEEF);
    add("stl2",  0, 4'h5, 0, 0, 0, 1, 0, 10'h000, 1, 2, 32'hAC0, 32'hDEADBEEF);
    add("stl3",  0, 4'h5, 0, 0, 0, 1, 0, 10'h000, 1, 2, 32'hAC0, 32'hDEADBEEF);
    add("stlr",  0, 4'h5, 0, 0, 0, 0, 1, 10'h023, 1, 2, 32'hAC0, 32'hDEADBEEF);
    add("stln",  0, 4'h5, 0, 0, 0, 0, 1, 10'h2B1, 1, 0, 32'h08C, 32'hC0DE0023);
    add("oth0",  0, 4'hF, 0, 0, 0, 0, 1, 10'h0C1, 1, 2, 32'hAC4, 32'hC0DE02B1);
    add("oth1",  0, 4'hF, 1, 1, 32'h500, 0, 1, 10'h024, 1, 3, 32'h304, 32'hC0DE00C1);
    add("oth2",  0, 4'hF, 0, 0, 0, 0, 1, 10'h140, 1, 0, 32'h090, 32'hC0DE0024);
    add("oth3",  0, 4'hF, 0, 0, 0, 0, 1, 10'h2B2, 1, 1, 32'h500, 32'hC0DE0140);
    add("hrs1",  0, 4'hF, 0, 0, 0, 1, 0, 10'h000, 1, 2, 32'hAC8, 32'hC0DE02B2);
    add("hrs2",  0, 4'hF, 0, 0, 0, 1, 0, 10'h000, 1, 2, 32'hAC8, 32'hC0DE02B2);
    add("hrs3",  1, 4'hF, 0, 0, 0, 1, 0, 10'h000, 0, 0, 32'h0,   32'h0);
    add("hrs4",  0, 4'hF, 0, 0, 0, 1, 1, 10'h000, 0, 0, 32'h0,   32'h0);
    add("hrs5",  0, 4'hF, 0, 0, 0, 0, 1, 10'h040, 1, 0, 32'h000, 32'hC0DE0000);
    add("dis1",  0, 4'h0, 0, 0, 0, 0, 0, 10'h000, 1, 1, 32'h100, 32'hC0DE0040);
    add("dis2",  0, 4'h0, 0, 0, 0, 0, 0, 10'h000, 0, 0, 32'h0,   32'h0);
    add("wrp0",  0, 4'h0, 1, 2, 32'hFFFFFFFF, 0, 0, 10'h000, 0, 0, 32'h0, 32'h0);
    add("wrp1",  0, 4'h4, 0, 0, 0, 0, 1, 10'h3FF, 0, 0, 32'h0,   32'h0);
    add("wrp2",  0, 4'h4, 0, 0, 0, 0, 1, 10'h000, 1, 2, 32'hFFFFFFFC, 32'hC0DE03FF);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Hand sequence: redirect kills an entry that is being held across a stall.
    h = '{name: "hk1", rst: 0, en: 4'h4, rv: 0, rtid: 0, rpc: 0, stall: 1,
          rden: 0, addr: 0, valid: 1, tid: 2, pc: 32'h0, inst: 32'hC0DE0000};
    run_vec(h);
    h = '{name: "hk2", rst: 0, en: 4'h4, rv: 1, rtid: 2, rpc: 32'h40, stall: 1,
          rden: 0, addr: 0, valid: 0, tid: 0, pc: 32'h0, inst: 32'h0};
    run_vec(h);
    h = '{name: "hk3", rst: 0, en: 4'h4, rv: 0, rtid: 0, rpc: 0, stall: 0,
          rden: 1, addr: 10'h010, valid: 0, tid: 0, pc: 32'h0, inst: 32'h0};
    run_vec(h);
    h = '{name: "hk4", rst: 0, en: 4'h4, rv: 0, rtid: 0, rpc: 0, stall: 0,
          rden: 1, addr: 10'h011, valid: 1, tid: 2, pc: 32'h40, inst: 32'hC0DE0010};
    run_vec(h);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
